// File: rtl/sampler_output_buffer_pkg.sv
// Shared types, constants and the output saturation helper for the sampler output buffer.
package sampler_output_pkg;

  localparam int         BLOCK_SIZE_DEFAULT = 64;
  localparam logic [7:0] GAIN_UNITY         = 8'd128;

  // Stereo sample as carried on the stream: right in the upper half, left in the lower.
  typedef struct packed {
    logic signed [15:0] right;
    logic signed [15:0] left;
  } stereo_sample_t;

  // Scale a 16x9 gain product back by 2^7 (Q1.7) and clamp it to the 16-bit signed range.
  function automatic logic signed [15:0] sat16(input logic signed [24:0] p);
    logic signed [24:0] s;
    s = p >>> 7;
    if (s > 25'sd32767) begin
      return 16'sh7FFF;
    end else if (s < -25'sd32768) begin
      return 16'sh8000;
    end else begin
      return s[15:0];
    end
  endfunction

endpackage

// File: rtl/sampler_output_buffer_if.sv
// AXI-Stream beat channel carrying mixed stereo blocks into the output buffer.
// Handshake: a beat transfers on a rising clk edge where tvalid and tready are both high;
// the master holds tdata/tlast/tuser stable while tvalid is high and tready is low.
interface sampler_output_buffer_if #(
  parameter int DATA_W = 32,
  parameter int USER_W = 32
);
  logic [DATA_W-1:0] tdata;
  logic              tvalid;
  logic              tlast;
  logic [USER_W-1:0] tuser;
  logic              tready;

  modport master (output tdata, output tvalid, output tlast, output tuser, input tready);
  modport slave  (input tdata, input tvalid, input tlast, input tuser, output tready);
endinterface

// File: rtl/sampler_output_bank_ram.sv
// Simple dual-port RAM holding both ping-pong banks; address is {bank, addr}.
module sampler_output_bank_ram #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 7
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [2**ADDR_W];
  logic [DATA_W-1:0] r_rdata;

  // Write port: one beat per cycle; contents are never reset so this maps onto block RAM.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Registered read port, enabled only when a sample is actually played.
  always_ff @(posedge clk) begin
    if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/sampler_output_buffer.sv
// Ping-pong block buffer between the mixer stream and the codec: one stereo sample
// per sample_tick, master gain with saturation, block_request when a bank frees up.
module sampler_output_buffer
  import sampler_output_pkg::*;
#(
  parameter int C_AXI_STREAM_TDATA_WIDTH = 32,
  parameter int C_AXI_STREAM_TUSER_WIDTH = 32,
  parameter int BLOCK_SIZE               = BLOCK_SIZE_DEFAULT
) (
  input  logic                   clk,
  input  logic                   reset_n,
  sampler_output_buffer_if.slave s_axis,
  input  logic                   sample_tick,
  input  logic [7:0]             gain,
  output logic signed [15:0]     out_left,
  output logic signed [15:0]     out_right,
  output logic                   out_valid,
  output logic                   block_request,
  output logic [15:0]            underrun_count,
  output logic                   block_error
);

  localparam int             AW        = $clog2(BLOCK_SIZE);
  localparam int             LW        = AW + 1;
  localparam logic [AW-1:0]  LAST_ADDR = AW'(BLOCK_SIZE - 1);
  localparam logic [LW-1:0]  ONE_L     = LW'(1);

  logic [1:0]             r_full;
  logic [LW-1:0]          r_len [2];
  logic                   r_wr_bank;
  logic [AW-1:0]          r_wr_addr;
  logic                   r_rd_bank;
  logic [AW-1:0]          r_rd_addr;
  logic                   r_s1_valid;
  logic                   r_s1_zero;
  logic signed [15:0]     r_out_left;
  logic signed [15:0]     r_out_right;
  logic                   r_out_valid;
  logic                   r_block_request;
  logic [15:0]            r_underrun_count;
  logic                   r_block_error;

  logic                   w_stop;
  logic                   w_tready;
  logic                   w_accept;
  logic                   w_close;
  logic                   w_play;
  logic                   w_underrun;
  logic                   w_rd_end;
  logic [C_AXI_STREAM_TDATA_WIDTH-1:0] w_rd_data;
  stereo_sample_t         w_rd_sample;
  logic signed [8:0]      w_gain_s;
  logic signed [24:0]     w_p_left;
  logic signed [24:0]     w_p_right;

  // A stop beat is always accepted, even into a full bank, and is never stored.
  assign w_stop     = s_axis.tvalid && (s_axis.tuser == '1);
  assign w_tready   = !r_full[r_wr_bank] || w_stop;
  assign w_accept   = s_axis.tvalid && w_tready && !w_stop;
  assign w_close    = w_accept && (s_axis.tlast || (r_wr_addr == LAST_ADDR));
  // Stop takes priority over a tick in the same cycle: no read, no underrun count.
  assign w_play     = sample_tick && r_full[r_rd_bank] && !w_stop;
  assign w_underrun = sample_tick && !r_full[r_rd_bank] && !w_stop;
  assign w_rd_end   = w_play && ({1'b0, r_rd_addr} == (r_len[r_rd_bank] - ONE_L));

  assign s_axis.tready = w_tready;

  sampler_output_bank_ram #(
    .DATA_W (C_AXI_STREAM_TDATA_WIDTH),
    .ADDR_W (AW + 1)
  ) u_bank_ram (
    .clk     (clk),
    .i_we    (w_accept),
    .i_waddr ({r_wr_bank, r_wr_addr}),
    .i_wdata (s_axis.tdata),
    .i_re    (w_play),
    .i_raddr ({r_rd_bank, r_rd_addr}),
    .o_rdata (w_rd_data)
  );

  // Gain is applied to the RAM output in the cycle after the tick.
  assign w_rd_sample = w_rd_data;
  assign w_gain_s    = $signed({1'b0, gain});
  assign w_p_left    = $signed(w_rd_sample.left) * w_gain_s;
  assign w_p_right   = $signed(w_rd_sample.right) * w_gain_s;

  // Write/read pointers and per-bank full/len. Close and free always hit different banks.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_full    <= '0;
      r_len[0]  <= '0;
      r_len[1]  <= '0;
      r_wr_bank <= 1'b0;
      r_wr_addr <= '0;
      r_rd_bank <= 1'b0;
      r_rd_addr <= '0;
    end else if (w_stop) begin
      r_full    <= '0;
      r_wr_bank <= 1'b0;
      r_wr_addr <= '0;
      r_rd_bank <= 1'b0;
      r_rd_addr <= '0;
    end else begin
      if (w_accept) begin
        if (w_close) begin
          r_full[r_wr_bank] <= 1'b1;
          r_len[r_wr_bank]  <= {1'b0, r_wr_addr} + ONE_L;
          r_wr_bank         <= ~r_wr_bank;
          r_wr_addr         <= '0;
        end else begin
          r_wr_addr <= r_wr_addr + 1'b1;
        end
      end
      if (w_play) begin
        if (w_rd_end) begin
          r_full[r_rd_bank] <= 1'b0;
          r_rd_bank         <= ~r_rd_bank;
          r_rd_addr         <= '0;
        end else begin
          r_rd_addr <= r_rd_addr + 1'b1;
        end
      end
    end
  end

  // Status: bank-free pulse, saturating underrun counter, sticky overlong-block flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_block_request  <= 1'b0;
      r_underrun_count <= '0;
      r_block_error    <= 1'b0;
    end else begin
      r_block_request <= w_rd_end;
      if (w_underrun && (r_underrun_count != 16'hFFFF)) begin
        r_underrun_count <= r_underrun_count + 16'd1;
      end
      if (w_close && !s_axis.tlast) begin
        r_block_error <= 1'b1;
      end
    end
  end

  // Output pipeline: stage 1 tracks the tick alongside the RAM read, stage 2 applies gain.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s1_valid  <= 1'b0;
      r_s1_zero   <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_left  <= '0;
      r_out_right <= '0;
    end else begin
      r_s1_valid  <= sample_tick;
      r_s1_zero   <= !w_play;
      r_out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_out_left  <= r_s1_zero ? 16'sd0 : sat16(w_p_left);
        r_out_right <= r_s1_zero ? 16'sd0 : sat16(w_p_right);
      end
    end
  end

  assign out_left       = r_out_left;
  assign out_right      = r_out_right;
  assign out_valid      = r_out_valid;
  assign block_request  = r_block_request;
  assign underrun_count = r_underrun_count;
  assign block_error    = r_block_error;

endmodule

// File: tb/tb_sampler_output_buffer.sv
// Directed bench for the sampler output buffer: full blocks, gain/saturation,
// back-pressure, short blocks with underrun, missing tlast, and stream stop.
module tb_sampler_output_buffer;

  logic               clk;
  logic               reset_n;
  logic               sample_tick;
  logic [7:0]         gain;
  logic signed [15:0] out_left;
  logic signed [15:0] out_right;
  logic               out_valid;
  logic               block_request;
  logic [15:0]        underrun_count;
  logic               block_error;

  int n_checks;
  int n_fail;
  logic [31:0] exp_q[$];

  sampler_output_buffer_if #(.DATA_W(32), .USER_W(32)) s_axis_if ();

  sampler_output_buffer #(
    .C_AXI_STREAM_TDATA_WIDTH (32),
    .C_AXI_STREAM_TUSER_WIDTH (32),
    .BLOCK_SIZE               (64)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .s_axis         (s_axis_if),
    .sample_tick    (sample_tick),
    .gain           (gain),
    .out_left       (out_left),
    .out_right      (out_right),
    .out_valid      (out_valid),
    .block_request  (block_request),
    .underrun_count (underrun_count),
    .block_error    (block_error)
  );

  // Clock and reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single comparison point for the whole bench.
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Present one beat and hold it until accepted (caller is 1 time unit after a rising edge).
  task automatic send_beat(input logic [31:0] d, input bit last, input logic [31:0] user);
    int t;
    s_axis_if.tdata  = d;
    s_axis_if.tlast  = last;
    s_axis_if.tuser  = user;
    s_axis_if.tvalid = 1'b1;
    t = 0;
    @(negedge clk);
    while (!s_axis_if.tready && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 2000) check("tready_timeout", {31'd0, s_axis_if.tready}, 32'd1);
    @(posedge clk);
    #1;
    s_axis_if.tvalid = 1'b0;
    s_axis_if.tlast  = 1'b0;
    s_axis_if.tuser  = '0;
  endtask

  // Sample k of a block is {right = -(base+k), left = base+k}; queued as unity-gain expectation.
  task automatic send_block(input int base, input int n, input bit last_on_end);
    logic [15:0] l;
    logic [15:0] r;
    for (int k = 0; k < n; k++) begin
      l = 16'(base + k);
      r = 16'(-(base + k));
      exp_q.push_back({r, l});
      send_beat({r, l}, last_on_end && (k == n - 1), 32'd0);
    end
  endtask

  // One tick: checks block_request in N+1, out_valid only in N+2, and the sample in N+2.
  task automatic do_tick(input string tag, input bit exp_br, input int gap);
    logic [31:0] e;
    sample_tick = 1'b1;
    @(posedge clk);
    #1;
    sample_tick = 1'b0;
    check({tag, "_br"}, {31'd0, block_request}, {31'd0, exp_br});
    check({tag, "_ov_n1"}, {31'd0, out_valid}, 32'd0);
    @(posedge clk);
    #1;
    check({tag, "_ov_n2"}, {31'd0, out_valid}, 32'd1);
    if (exp_q.size() == 0) begin
      check({tag, "_expq_empty"}, 32'(exp_q.size()), 32'd1);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_data"}, {out_right, out_left}, e);
    end
    repeat (gap) @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks         = 0;
    n_fail           = 0;
    reset_n          = 1'b0;
    sample_tick      = 1'b0;
    gain             = 8'd128;
    s_axis_if.tdata  = '0;
    s_axis_if.tvalid = 1'b0;
    s_axis_if.tlast  = 1'b0;
    s_axis_if.tuser  = '0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_tready", {31'd0, s_axis_if.tready}, 32'd1);
    check("rst_out", {out_right, out_left}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_block_request", {31'd0, block_request}, 32'd0);
    check("rst_underrun", {16'd0, underrun_count}, 32'd0);
    check("rst_block_error", {31'd0, block_error}, 32'd0);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Full 64-beat block at unity gain, ticks every 10 cycles.
    send_block(1, 64, 1'b1);
    for (int k = 0; k < 64; k++) do_tick("full", k == 63, 8);

    // Gain and saturation on a two-beat block.
    gain = 8'd255;
    exp_q.push_back({16'h8000, 16'h7FFF});
    send_beat({16'h9000, 16'h7000}, 1'b0, 32'd0);
    exp_q.push_back({16'hC800, 16'h3800});
    send_beat({16'h9000, 16'h7000}, 1'b1, 32'd0);
    do_tick("gain255", 1'b0, 2);
    gain = 8'd64;
    do_tick("gain64", 1'b1, 2);
    gain = 8'd128;

    // Back-pressure: two blocks fill both banks; the third waits for the first free.
    send_block(1000, 64, 1'b1);
    send_block(2000, 64, 1'b1);
    check("bp_full_tready", {31'd0, s_axis_if.tready}, 32'd0);
    fork
      send_block(3000, 64, 1'b1);
      begin
        for (int k = 0; k < 64; k++) begin
          do_tick("bp_blk1", k == 63, 2);
          check("bp_tready", {31'd0, s_axis_if.tready}, {31'd0, (k == 63)});
        end
      end
    join
    for (int k = 0; k < 64; k++) do_tick("bp_blk2", k == 63, 2);
    for (int k = 0; k < 64; k++) do_tick("bp_blk3", k == 63, 2);

    // Short block followed by two underrun ticks.
    send_block(100, 10, 1'b1);
    for (int k = 0; k < 10; k++) do_tick("short", k == 9, 2);
    exp_q.push_back(32'd0);
    exp_q.push_back(32'd0);
    do_tick("under1", 1'b0, 2);
    do_tick("under2", 1'b0, 2);
    check("underrun_cnt2", {16'd0, underrun_count}, 32'd2);

    // Missing tlast: 70 beats close bank 0 at 64 and leave 6 beats open in bank 1.
    send_block(200, 70, 1'b0);
    check("blk_err_set", {31'd0, block_error}, 32'd1);
    for (int k = 0; k < 64; k++) do_tick("notlast_b0", k == 63, 2);
    exp_q.push_front(32'd0);
    do_tick("open_bank_under", 1'b0, 2);
    check("underrun_cnt3", {16'd0, underrun_count}, 32'd3);
    send_block(270, 1, 1'b1);
    for (int k = 0; k < 7; k++) do_tick("notlast_b1", k == 6, 2);
    check("blk_err_sticky", {31'd0, block_error}, 32'd1);

    // Stop: half-filled bank dropped; stop beat and tick in the same cycle.
    for (int k = 0; k < 32; k++) send_beat({16'(-(300 + k)), 16'(300 + k)}, 1'b0, 32'd0);
    s_axis_if.tdata  = 32'h1234_5678;
    s_axis_if.tuser  = '1;
    s_axis_if.tvalid = 1'b1;
    sample_tick      = 1'b1;
    @(negedge clk);
    check("stop_tready", {31'd0, s_axis_if.tready}, 32'd1);
    @(posedge clk);
    #1;
    s_axis_if.tvalid = 1'b0;
    s_axis_if.tuser  = '0;
    sample_tick      = 1'b0;
    check("stop_br", {31'd0, block_request}, 32'd0);
    check("stop_underrun", {16'd0, underrun_count}, 32'd3);
    @(posedge clk);
    #1;
    check("stop_ov", {31'd0, out_valid}, 32'd1);
    check("stop_out", {out_right, out_left}, 32'd0);
    @(posedge clk);
    #1;
    send_block(400, 64, 1'b1);
    for (int k = 0; k < 64; k++) do_tick("after_stop", k == 63, 2);
    check("final_underrun", {16'd0, underrun_count}, 32'd3);
    check("final_expq", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global time limit so the run always ends with a summary.
  initial begin
    #2000000;
    check("global_timeout", 32'(exp_q.size()), 32'hFFFF_FFFF);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
